usart_tx: RTL

- Transmit half of the USART link: serialises bytes from the core onto `tx` as asynchronous frames (start, data LSB-first, optional parity, stop).
- Frame timing and line polarity mirror what the USART_Controller receive path samples on `rx`.
- Default timing is 434 clocks per bit, matching the bench's 868-time-unit bit period with a 2-unit clock period.
- A small input FIFO decouples the core from bit timing, so back-to-back bytes leave with no idle gap.

---
 rtl/usart_pkg.sv | 37 +++
 rtl/usart_fifo.sv | 63 ++++++
 rtl/usart_tx.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/usart_pkg.sv
// Shared definitions for the USART transmit and receive paths:
// FSM state encoding, parity codes, default bit timing and small helpers.
package usart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int DEFAULT_CLKS_PER_BIT = 434;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // Narrower data words are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/usart_fifo.sv
// Synchronous single-clock first-word-fall-through FIFO with occupancy count.
// Push when full and pop when empty are ignored.
module usart_fifo
    import usart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign push_ok_s  = push_i & ~full_o;
    assign pop_ok_s   = pop_i & ~empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/usart_tx.sv
// USART transmitter: buffers bytes in a small FIFO and serialises them as
// start / LSB-first data / optional parity / stop frames on a registered tx line.
module usart_tx
    import usart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    localparam int CNT_W       = clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic [CNT_W-1:0]     fifo_count
);

    localparam int BAUD_W = clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

    tx_state_e              state_q, state_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;

    logic                   fifo_pop_s;
    logic [DATA_BITS-1:0]   fifo_data_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic                   bit_end_s;

    usart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (tx_valid & tx_ready),
        .push_data_i (tx_data),
        .pop_i       (fifo_pop_s),
        .pop_data_o  (fifo_data_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .count_o     (fifo_count)
    );

    assign tx_ready  = ~fifo_full_s;
    assign tx        = tx_q;
    assign busy      = (state_q != ST_IDLE) | (fifo_count != '0);
    assign bit_end_s = (baud_q == BAUD_LAST);

    // Next-state logic; popping in IDLE or on the last stop cycle makes the start bit begin on the next edge.
    always_comb begin
        state_d    = state_q;
        baud_d     = bit_end_s ? '0 : baud_q + BAUD_W'(1);
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tx_d       = tx_q;
        fifo_pop_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                bit_d  = 4'd0;
                tx_d   = 1'b1;
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    shift_d    = fifo_data_s;
                    par_d      = parity_bit(8'(fifo_data_s), PARITY);
                    tx_d       = 1'b0;
                    state_d    = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                    bit_d   = 4'd0;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (!bit_end_s) begin
                    state_d = ST_DATA;
                end else if (bit_q != DATA_LAST) begin
                    bit_d   = bit_q + 4'd1;
                    shift_d = shift_q >> 1;
                    tx_d    = shift_q[1];
                end else if (PARITY != PAR_NONE) begin
                    state_d = ST_PARITY;
                    tx_d    = par_q;
                end else begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                    bit_d   = 4'd0;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                    bit_d   = 4'd0;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (!bit_end_s) begin
                    state_d = ST_STOP;
                end else if (bit_q != STOP_LAST) begin
                    bit_d = bit_q + 4'd1;
                end else if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    shift_d    = fifo_data_s;
                    par_d      = parity_bit(8'(fifo_data_s), PARITY);
                    tx_d       = 1'b0;
                    bit_d      = 4'd0;
                    state_d    = ST_START;
                end else begin
                    tx_d    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State, counters and the registered line driver.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= 4'd0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

endmodule
